// File: rtl/dmux8way_router_pkg.sv
// Shared constants and helpers for the 1-to-8 word distributor.
package dmux8way_router_pkg;

    localparam int LANES       = 8;
    localparam int SEL_WIDTH   = 3;
    localparam int COUNT_WIDTH = 16;

    function automatic logic [LANES-1:0] decode_select(input logic [SEL_WIDTH-1:0] sel);
        logic [LANES-1:0] onehot;
        onehot      = '0;
        onehot[sel] = 1'b1;
        return onehot;
    endfunction

endpackage

// File: rtl/dmux8way_router_lane.sv
// One-entry holding register for a single output lane; a write wins over a read on the same edge.
module dmux8way_router_lane #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             write_en,
    input  logic             read_en,
    input  logic [WIDTH-1:0] data_in,
    output logic             full,
    output logic [WIDTH-1:0] data_out
);

    // NOTE: the data register is reset too so every lane reads as zero after reset;
    // sequential state is always assigned with <= so all lanes update from the same pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full     <= 1'b0;
            data_out <= '0;
        end else if (write_en) begin
            full     <= 1'b1;
            data_out <= data_in;
        end else if (read_en) begin
            full     <= 1'b0;
        end
    end

endmodule

// File: rtl/dmux8way_router.sv
// Registered 1-to-8 word distributor with an independent valid/ready holding register per lane.
module dmux8way_router
    import dmux8way_router_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [SEL_WIDTH-1:0]   in_select,
    input  logic [WIDTH-1:0]       in_data,
    output logic [LANES-1:0]       out_valid,
    input  logic [LANES-1:0]       out_ready,
    output logic [LANES*WIDTH-1:0] out_data,
    output logic [COUNT_WIDTH-1:0] accept_count
);

    logic             in_xfer;
    logic [LANES-1:0] write_en;
    logic [LANES-1:0] read_en;

    // A full lane can still accept when its consumer drains it on the same edge.
    assign in_ready = !out_valid[in_select] || out_ready[in_select];
    assign in_xfer  = in_valid && in_ready;
    assign write_en = in_xfer ? decode_select(in_select) : '0;
    assign read_en  = out_valid & out_ready;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        dmux8way_router_lane #(.WIDTH(WIDTH)) u_lane (
            .clk      (clk),
            .reset    (reset),
            .write_en (write_en[k]),
            .read_en  (read_en[k]),
            .data_in  (in_data),
            .full     (out_valid[k]),
            .data_out (out_data[k*WIDTH +: WIDTH])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            accept_count <= '0;
        end else if (in_xfer) begin
            accept_count <= accept_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_dmux8way_router.sv
// Directed bench for dmux8way_router: vector table plus hand-written multi-cycle sequences.
module tb_dmux8way_router;

    typedef struct {
        logic        valid;
        logic [2:0]  sel;
        logic [15:0] data;
        logic [7:0]  ready;
        logic        exp_in_ready;
        logic [7:0]  exp_valid;
        logic [15:0] exp_lane_data;
        logic [15:0] exp_count;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   in_select;
    logic [15:0]  in_data;
    logic [7:0]   out_valid;
    logic [7:0]   out_ready;
    logic [127:0] out_data;
    logic [15:0]  accept_count;

    int checks = 0;
    int errors = 0;

    dmux8way_router #(.WIDTH(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_select    (in_select),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .accept_count (accept_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] lane(input int k);
        return out_data[k*16 +: 16];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " out_valid"}, 32'(out_valid), 32'h0);
        check({tag, " accept_count"}, 32'(accept_count), 32'h0);
        check({tag, " out_data"}, 32'(out_data != '0), 32'h0);
        check({tag, " in_ready"}, 32'(in_ready), 32'h1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
    endtask

    vec_t vecs[14];

    initial begin
        // Fan-out to all eight lanes, consumers stalled.
        for (int k = 0; k < 8; k++) begin
            vecs[k] = '{1'b1, 3'(k), 16'h1000 + 16'(k), 8'h00, 1'b1,
                        8'((16'd1 << (k + 1)) - 16'd1), 16'h1000 + 16'(k), 16'(k + 1)};
        end
        // Lane 5: simultaneous drain+write, then stall, then release.
        vecs[8]  = '{1'b1, 3'd5, 16'hAAAA, 8'h20, 1'b1, 8'hFF, 16'hAAAA, 16'd9};
        vecs[9]  = '{1'b1, 3'd5, 16'hBBBB, 8'h00, 1'b0, 8'hFF, 16'hAAAA, 16'd9};
        vecs[10] = '{1'b1, 3'd5, 16'hBBBB, 8'h20, 1'b1, 8'hFF, 16'hBBBB, 16'd10};
        // Drain lane 6 with no input, then refill it while lane 2 stays stalled.
        vecs[11] = '{1'b0, 3'd6, 16'hDEAD, 8'h40, 1'b1, 8'hBF, 16'h1006, 16'd10};
        vecs[12] = '{1'b1, 3'd6, 16'h0042, 8'h00, 1'b1, 8'hFF, 16'h0042, 16'd11};
        vecs[13] = '{1'b1, 3'd2, 16'h5555, 8'h00, 1'b0, 8'hFF, 16'h1002, 16'd11};

        in_valid  = 1'b0;
        in_select = 3'd0;
        in_data   = 16'h0;
        out_ready = 8'h00;

        reset = 1'b1;
        #1;
        check_reset_state("reset_held");
        do_reset();
        check_reset_state("after_reset");

        for (int i = 0; i < 14; i++) begin
            in_valid  = vecs[i].valid;
            in_select = vecs[i].sel;
            in_data   = vecs[i].data;
            out_ready = vecs[i].ready;
            #1;
            check($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(vecs[i].exp_in_ready));
            tick();
            check($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d lane_data", i), 32'(lane(int'(vecs[i].sel))), 32'(vecs[i].exp_lane_data));
            check($sformatf("vec%0d accept_count", i), 32'(accept_count), 32'(vecs[i].exp_count));
            if (i == 7) begin
                for (int k = 0; k < 8; k++)
                    check($sformatf("fanout lane%0d", k), 32'(lane(k)), 32'h1000 + 32'(k));
            end
        end
        in_valid = 1'b0;
        check("nonblock lane2 unchanged", 32'(lane(2)), 32'h1002);
        check("backpressure lane5 final", 32'(lane(5)), 32'hBBBB);

        // Asynchronous reset mid-cycle while lane 3 is full and stalled.
        out_ready = 8'h00;
        #2;
        reset = 1'b1;
        #1;
        check_reset_state("async_reset");
        repeat (2) tick();
        reset = 1'b0;
        tick();
        check_reset_state("post_async_reset");

        // Streaming 16 words through lane 0 with the consumer always ready.
        out_ready = 8'h01;
        for (int i = 1; i <= 16; i++) begin
            in_valid  = 1'b1;
            in_select = 3'd0;
            in_data   = 16'(i);
            #1;
            check($sformatf("stream%0d in_ready", i), 32'(in_ready), 32'h1);
            tick();
            check($sformatf("stream%0d valid", i), 32'(out_valid[0]), 32'h1);
            check($sformatf("stream%0d data", i), 32'(lane(0)), 32'(i));
        end
        in_valid = 1'b0;
        tick();
        check("stream drained", 32'(out_valid), 32'h0);
        check("stream count", 32'(accept_count), 32'd16);

        // Counter wrap with every consumer ready.
        do_reset();
        out_ready = 8'hFF;
        in_valid  = 1'b1;
        for (int i = 0; i < 65537; i++) begin
            in_select = 3'($urandom_range(0, 7));
            in_data   = 16'($urandom);
            tick();
            if (i == 65535)
                check("count wrap to zero", 32'(accept_count), 32'h0);
        end
        in_valid = 1'b0;
        check("count after 65537", 32'(accept_count), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
